// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Request/response bus of the three requesters plus the shared
//                memory handshake, as seen by the arbiter (slave) and by the
//                surrounding system (master).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;

    // Requester side: 3 ports packed side by side, port N in slice N
    logic [2:0]  req_valid;
    logic [2:0]  req_write;
    logic [5:0]  req_size;
    logic [95:0] req_addr;
    logic [95:0] req_wdata;
    logic [2:0]  req_ack;
    logic [2:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_fault;

    // Shared memory port
    logic        mem_valid;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_fault;

    // Arbiter view
    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        input  mem_ready, mem_rdata, mem_fault,
        output req_ack, rsp_valid, rsp_rdata, rsp_fault,
        output mem_valid, mem_write, mem_size, mem_addr, mem_wdata
    );

    // System view: requesters and the memory model
    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        output mem_ready, mem_rdata, mem_fault,
        input  req_ack, rsp_valid, rsp_rdata, rsp_fault,
        input  mem_valid, mem_write, mem_size, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Three-port round-robin memory arbiter. Grants one transaction
//                at a time, rejects illegal size / misaligned accesses, drives
//                the memory handshake with a response timeout and returns
//                read data plus a fault code to the owning requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0]  c_IDLE = 2'd0;
    localparam logic [1:0]  c_BUSY = 2'd1;
    localparam logic [1:0]  c_RESP = 2'd2;

    localparam logic [1:0]  c_FAULT_OK      = 2'b00;
    localparam logic [1:0]  c_FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0]  c_FAULT_BUS     = 2'b10;
    localparam logic [1:0]  c_FAULT_TIMEOUT = 2'b11;

    // Last counter value before the timeout fires (counter starts at 0)
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  r_rr_ptr;
    logic [15:0] r_cnt;
    logic [1:0]  r_owner;
    logic        r_write;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic [1:0]  r_rsp_fault;

    logic [1:0]  w_order0;
    logic [1:0]  w_order1;
    logic [1:0]  w_order2;
    logic        w_grant;
    logic [1:0]  w_winner;
    logic        w_sel_write;
    logic [1:0]  w_sel_size;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_illegal;

    // Port index successor modulo 3
    function automatic logic [1:0] f_next_port(input logic [1:0] p);
        f_next_port = (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Port index to one-hot owner vector
    function automatic logic [2:0] f_onehot(input logic [1:0] p);
        f_onehot = 3'b001 << p;
    endfunction

    // Round-robin search upward from the pointer
    always_comb begin
        w_order0 = r_rr_ptr;
        w_order1 = f_next_port(r_rr_ptr);
        w_order2 = f_next_port(w_order1);
        w_grant  = 1'b0;
        w_winner = w_order0;
        if (bus.req_valid[w_order0]) begin
            w_grant  = 1'b1;
            w_winner = w_order0;
        end else if (bus.req_valid[w_order1]) begin
            w_grant  = 1'b1;
            w_winner = w_order1;
        end else if (bus.req_valid[w_order2]) begin
            w_grant  = 1'b1;
            w_winner = w_order2;
        end
    end

    // Select the winning port's request fields
    always_comb begin
        case (w_winner)
            2'd1: begin
                w_sel_write = bus.req_write[1];
                w_sel_size  = bus.req_size[3:2];
                w_sel_addr  = bus.req_addr[63:32];
                w_sel_wdata = bus.req_wdata[63:32];
            end
            2'd2: begin
                w_sel_write = bus.req_write[2];
                w_sel_size  = bus.req_size[5:4];
                w_sel_addr  = bus.req_addr[95:64];
                w_sel_wdata = bus.req_wdata[95:64];
            end
            default: begin
                w_sel_write = bus.req_write[0];
                w_sel_size  = bus.req_size[1:0];
                w_sel_addr  = bus.req_addr[31:0];
                w_sel_wdata = bus.req_wdata[31:0];
            end
        endcase
    end

    // Size 11 is reserved; halves need addr[0]=0, words need addr[1:0]=0
    assign w_illegal = (w_sel_size == 2'b11) ||
                       ((w_sel_size == 2'b01) && w_sel_addr[0]) ||
                       ((w_sel_size == 2'b10) && (w_sel_addr[1:0] != 2'b00));

    // Acknowledge only from IDLE and never while reset is held
    assign bus.req_ack = (!reset && (r_state == c_IDLE) && w_grant) ?
                         f_onehot(w_winner) : 3'b000;

    assign bus.mem_valid = (r_state == c_BUSY);
    assign bus.mem_write = r_write;
    assign bus.mem_size  = r_size;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_fault = r_rsp_fault;

    // Transaction sequencer: grant, memory handshake with timeout, response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_rr_ptr    <= 2'd0;
            r_cnt       <= 16'd0;
            r_owner     <= 2'd0;
            r_write     <= 1'b0;
            r_size      <= 2'b00;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rsp_valid <= 3'b000;
            r_rsp_rdata <= 32'd0;
            r_rsp_fault <= c_FAULT_OK;
        end else begin
            r_rsp_valid <= 3'b000;
            case (r_state)
                c_IDLE: begin
                    if (w_grant) begin
                        r_owner  <= w_winner;
                        r_write  <= w_sel_write;
                        r_size   <= w_sel_size;
                        r_addr   <= w_sel_addr;
                        r_wdata  <= w_sel_wdata;
                        r_rr_ptr <= f_next_port(w_winner);
                        if (w_illegal) begin
                            r_rsp_fault <= c_FAULT_ILLEGAL;
                            r_rsp_rdata <= 32'd0;
                            r_rsp_valid <= f_onehot(w_winner);
                            r_state     <= c_RESP;
                        end else begin
                            r_cnt   <= 16'd0;
                            r_state <= c_BUSY;
                        end
                    end
                end
                c_BUSY: begin
                    // A ready on the timeout edge still completes normally
                    if (bus.mem_ready) begin
                        r_rsp_rdata <= (r_write || bus.mem_fault) ? 32'd0 : bus.mem_rdata;
                        r_rsp_fault <= bus.mem_fault ? c_FAULT_BUS : c_FAULT_OK;
                        r_rsp_valid <= f_onehot(r_owner);
                        r_state     <= c_RESP;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_rsp_rdata <= 32'd0;
                        r_rsp_fault <= c_FAULT_TIMEOUT;
                        r_rsp_valid <= f_onehot(r_owner);
                        r_state     <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter, built with a
//                4-cycle response timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    mem_arbiter_if bus_if ();

    mem_arbiter #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.req_valid = 3'b000;
        bus_if.req_write = 3'b000;
        bus_if.req_size  = 6'b000000;
        bus_if.req_addr  = 96'd0;
        bus_if.req_wdata = 96'd0;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = 32'd0;
        bus_if.mem_fault = 1'b0;
    endtask

    // One-cycle synchronous reset; returns in IDLE just after the edge
    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        bus_if.req_valid = 3'b111;
        bus_if.req_size  = 6'b101010;
        step();
        step();
        #1;
        n_total++; if (bus_if.req_ack !== 3'b000) $display("FAIL reset_ack: got %b want 000", bus_if.req_ack); else n_pass++;
        n_total++; if (bus_if.mem_valid !== 1'b0) $display("FAIL reset_mem_valid: got %b want 0", bus_if.mem_valid); else n_pass++;
        n_total++; if (bus_if.rsp_valid !== 3'b000) $display("FAIL reset_rsp_valid: got %b want 000", bus_if.rsp_valid); else n_pass++;
        n_total++; if (bus_if.rsp_fault !== 2'b00) $display("FAIL reset_rsp_fault: got %b want 00", bus_if.rsp_fault); else n_pass++;
        n_total++; if (bus_if.rsp_rdata !== 32'd0) $display("FAIL reset_rsp_rdata: got %h want 0", bus_if.rsp_rdata); else n_pass++;
        n_total++; if (bus_if.mem_addr !== 32'd0) $display("FAIL reset_mem_addr: got %h want 0", bus_if.mem_addr); else n_pass++;
        n_total++; if (bus_if.mem_size !== 2'b00) $display("FAIL reset_mem_size: got %b want 00", bus_if.mem_size); else n_pass++;
        n_total++; if (bus_if.mem_write !== 1'b0) $display("FAIL reset_mem_write: got %b want 0", bus_if.mem_write); else n_pass++;
        n_total++; if (bus_if.mem_wdata !== 32'd0) $display("FAIL reset_mem_wdata: got %h want 0", bus_if.mem_wdata); else n_pass++;
        clear_inputs();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        apply_reset();
        bus_if.req_size[1:0]  = 2'b10;
        bus_if.req_addr[31:0] = 32'h0000_0100;
        bus_if.req_valid      = 3'b001;
        #1;
        n_total++; if (bus_if.req_ack !== 3'b001) $display("FAIL rd_ack: got %b want 001", bus_if.req_ack); else n_pass++;
        step();
        bus_if.req_valid = 3'b000;
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'hDEAD_BEEF;
        #1;
        n_total++; if (bus_if.mem_valid !== 1'b1) $display("FAIL rd_mem_valid: got %b want 1", bus_if.mem_valid); else n_pass++;
        n_total++; if (bus_if.mem_addr !== 32'h100) $display("FAIL rd_mem_addr: got %h want 00000100", bus_if.mem_addr); else n_pass++;
        n_total++; if (bus_if.mem_size !== 2'b10) $display("FAIL rd_mem_size: got %b want 10", bus_if.mem_size); else n_pass++;
        n_total++; if (bus_if.req_ack !== 3'b000) $display("FAIL rd_busy_ack: got %b want 000", bus_if.req_ack); else n_pass++;
        step();
        bus_if.mem_ready = 1'b0;
        #1;
        n_total++; if (bus_if.rsp_valid !== 3'b001) $display("FAIL rd_rsp_valid: got %b want 001", bus_if.rsp_valid); else n_pass++;
        n_total++; if (bus_if.rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_rsp_rdata: got %h want deadbeef", bus_if.rsp_rdata); else n_pass++;
        n_total++; if (bus_if.rsp_fault !== 2'b00) $display("FAIL rd_rsp_fault: got %b want 00", bus_if.rsp_fault); else n_pass++;
        n_total++; if (bus_if.mem_valid !== 1'b0) $display("FAIL rd_resp_mem_valid: got %b want 0", bus_if.mem_valid); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_oh;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        apply_reset();
        bus_if.req_size  = 6'b101010;
        bus_if.req_addr  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        bus_if.req_valid = 3'b111;
        bus_if.mem_ready = 1'b1;
        for (int g = 0; g < 6; g++) begin
            exp_oh   = 3'b001 << (g % 3);
            exp_addr = 32'((g % 3) + 1) << 8;
            exp_data = 32'hA000_0000 + 32'(g);
            bus_if.mem_rdata = exp_data;
            #1;
            n_total++; if (bus_if.req_ack !== exp_oh) $display("FAIL rr_ack[%0d]: got %b want %b", g, bus_if.req_ack, exp_oh); else n_pass++;
            step();
            #1;
            n_total++; if (bus_if.mem_addr !== exp_addr) $display("FAIL rr_mem_addr[%0d]: got %h want %h", g, bus_if.mem_addr, exp_addr); else n_pass++;
            step();
            #1;
            n_total++; if (bus_if.rsp_valid !== exp_oh) $display("FAIL rr_rsp_valid[%0d]: got %b want %b", g, bus_if.rsp_valid, exp_oh); else n_pass++;
            n_total++; if (bus_if.rsp_rdata !== exp_data) $display("FAIL rr_rsp_rdata[%0d]: got %h want %h", g, bus_if.rsp_rdata, exp_data); else n_pass++;
            n_total++; if (bus_if.req_ack !== 3'b000) $display("FAIL rr_resp_ack[%0d]: got %b want 000", g, bus_if.req_ack); else n_pass++;
            step();
        end
        clear_inputs();
    endtask

    task automatic test_illegal();
        apply_reset();
        // Half write at odd address on port 1
        bus_if.req_write        = 3'b010;
        bus_if.req_size         = 6'b000100;
        bus_if.req_addr[63:32]  = 32'h0000_0101;
        bus_if.req_wdata[63:32] = 32'h0000_BEEF;
        bus_if.req_valid        = 3'b010;
        #1;
        n_total++; if (bus_if.req_ack !== 3'b010) $display("FAIL mis_ack: got %b want 010", bus_if.req_ack); else n_pass++;
        step();
        bus_if.req_valid = 3'b000;
        #1;
        n_total++; if (bus_if.mem_valid !== 1'b0) $display("FAIL mis_mem_valid: got %b want 0", bus_if.mem_valid); else n_pass++;
        n_total++; if (bus_if.rsp_valid !== 3'b010) $display("FAIL mis_rsp_valid: got %b want 010", bus_if.rsp_valid); else n_pass++;
        n_total++; if (bus_if.rsp_fault !== 2'b01) $display("FAIL mis_rsp_fault: got %b want 01", bus_if.rsp_fault); else n_pass++;
        n_total++; if (bus_if.rsp_rdata !== 32'd0) $display("FAIL mis_rsp_rdata: got %h want 0", bus_if.rsp_rdata); else n_pass++;
        step();
        #1;
        n_total++; if (bus_if.mem_valid !== 1'b0) $display("FAIL mis_idle_mem_valid: got %b want 0", bus_if.mem_valid); else n_pass++;
        n_total++; if (bus_if.rsp_valid !== 3'b000) $display("FAIL mis_idle_rsp_valid: got %b want 000", bus_if.rsp_valid); else n_pass++;
        // Reserved size 11 at address 0 on port 1
        bus_if.req_write       = 3'b000;
        bus_if.req_size        = 6'b001100;
        bus_if.req_addr[63:32] = 32'd0;
        bus_if.req_valid       = 3'b010;
        #1;
        n_total++; if (bus_if.req_ack !== 3'b010) $display("FAIL sz3_ack: got %b want 010", bus_if.req_ack); else n_pass++;
        step();
        bus_if.req_valid = 3'b000;
        #1;
        n_total++; if (bus_if.mem_valid !== 1'b0) $display("FAIL sz3_mem_valid: got %b want 0", bus_if.mem_valid); else n_pass++;
        n_total++; if (bus_if.rsp_valid !== 3'b010) $display("FAIL sz3_rsp_valid: got %b want 010", bus_if.rsp_valid); else n_pass++;
        n_total++; if (bus_if.rsp_fault !== 2'b01) $display("FAIL sz3_rsp_fault: got %b want 01", bus_if.rsp_fault); else n_pass++;
        step();
        clear_inputs();
    endtask

    task automatic test_bus_fault();
        apply_reset();
        bus_if.req_size[5:4]   = 2'b10;
        bus_if.req_addr[95:64] = 32'h0000_0200;
        bus_if.req_valid       = 3'b100;
        #1;
        n_total++; if (bus_if.req_ack !== 3'b100) $display("FAIL bf_ack: got %b want 100", bus_if.req_ack); else n_pass++;
        step();
        bus_if.req_valid = 3'b000;
        #1;
        n_total++; if (bus_if.mem_valid !== 1'b1) $display("FAIL bf_mem_valid: got %b want 1", bus_if.mem_valid); else n_pass++;
        step();
        step();
        bus_if.mem_ready = 1'b1;
        bus_if.mem_fault = 1'b1;
        bus_if.mem_rdata = 32'h0000_1234;
        step();
        bus_if.mem_ready = 1'b0;
        bus_if.mem_fault = 1'b0;
        #1;
        n_total++; if (bus_if.rsp_valid !== 3'b100) $display("FAIL bf_rsp_valid: got %b want 100", bus_if.rsp_valid); else n_pass++;
        n_total++; if (bus_if.rsp_fault !== 2'b10) $display("FAIL bf_rsp_fault: got %b want 10", bus_if.rsp_fault); else n_pass++;
        n_total++; if (bus_if.rsp_rdata !== 32'd0) $display("FAIL bf_rsp_rdata: got %h want 0", bus_if.rsp_rdata); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_timeout();
        apply_reset();
        bus_if.req_size[1:0]  = 2'b10;
        bus_if.req_addr[31:0] = 32'h0000_0040;
        bus_if.req_valid      = 3'b001;
        #1;
        n_total++; if (bus_if.req_ack !== 3'b001) $display("FAIL to_ack: got %b want 001", bus_if.req_ack); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step();
            bus_if.req_valid = 3'b000;
            #1;
            n_total++; if (bus_if.mem_valid !== 1'b1) $display("FAIL to_mem_valid[%0d]: got %b want 1", i, bus_if.mem_valid); else n_pass++;
        end
        step();
        // Next request from port 1 raised while the timeout response is out
        bus_if.req_size[3:2]   = 2'b10;
        bus_if.req_addr[63:32] = 32'h0000_0080;
        bus_if.req_valid       = 3'b010;
        #1;
        n_total++; if (bus_if.mem_valid !== 1'b0) $display("FAIL to_end_mem_valid: got %b want 0", bus_if.mem_valid); else n_pass++;
        n_total++; if (bus_if.rsp_valid !== 3'b001) $display("FAIL to_rsp_valid: got %b want 001", bus_if.rsp_valid); else n_pass++;
        n_total++; if (bus_if.rsp_fault !== 2'b11) $display("FAIL to_rsp_fault: got %b want 11", bus_if.rsp_fault); else n_pass++;
        n_total++; if (bus_if.rsp_rdata !== 32'd0) $display("FAIL to_rsp_rdata: got %h want 0", bus_if.rsp_rdata); else n_pass++;
        n_total++; if (bus_if.req_ack !== 3'b000) $display("FAIL to_resp_ack: got %b want 000", bus_if.req_ack); else n_pass++;
        step();
        #1;
        n_total++; if (bus_if.req_ack !== 3'b010) $display("FAIL to_next_ack: got %b want 010", bus_if.req_ack); else n_pass++;
        // Ready arrives on the 4th BUSY cycle: completion beats the timeout
        for (int i = 0; i < 4; i++) begin
            step();
            bus_if.req_valid = 3'b000;
            if (i == 3) begin
                bus_if.mem_ready = 1'b1;
                bus_if.mem_rdata = 32'h5555_AAAA;
            end
            #1;
            n_total++; if (bus_if.mem_valid !== 1'b1) $display("FAIL to4_mem_valid[%0d]: got %b want 1", i, bus_if.mem_valid); else n_pass++;
        end
        step();
        bus_if.mem_ready = 1'b0;
        #1;
        n_total++; if (bus_if.rsp_valid !== 3'b010) $display("FAIL to4_rsp_valid: got %b want 010", bus_if.rsp_valid); else n_pass++;
        n_total++; if (bus_if.rsp_fault !== 2'b00) $display("FAIL to4_rsp_fault: got %b want 00", bus_if.rsp_fault); else n_pass++;
        n_total++; if (bus_if.rsp_rdata !== 32'h5555_AAAA) $display("FAIL to4_rsp_rdata: got %h want 5555aaaa", bus_if.rsp_rdata); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_reset_mid_busy();
        apply_reset();
        bus_if.req_size        = 6'b101010;
        bus_if.req_addr[63:32] = 32'h0000_0010;
        bus_if.req_valid       = 3'b010;
        #1;
        n_total++; if (bus_if.req_ack !== 3'b010) $display("FAIL rmb_ack: got %b want 010", bus_if.req_ack); else n_pass++;
        step();
        bus_if.req_valid = 3'b000;
        #1;
        n_total++; if (bus_if.mem_valid !== 1'b1) $display("FAIL rmb_busy: got %b want 1", bus_if.mem_valid); else n_pass++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_total++; if (bus_if.mem_valid !== 1'b0) $display("FAIL rmb_mem_valid: got %b want 0", bus_if.mem_valid); else n_pass++;
        n_total++; if (bus_if.rsp_valid !== 3'b000) $display("FAIL rmb_rsp_valid: got %b want 000", bus_if.rsp_valid); else n_pass++;
        bus_if.req_addr[31:0]  = 32'h0000_0020;
        bus_if.req_addr[95:64] = 32'h0000_0030;
        bus_if.req_valid       = 3'b101;
        #1;
        n_total++; if (bus_if.req_ack !== 3'b001) $display("FAIL rmb_ptr_ack: got %b want 001", bus_if.req_ack); else n_pass++;
        step();
        bus_if.req_valid = 3'b000;
        #1;
        n_total++; if (bus_if.mem_addr !== 32'h20) $display("FAIL rmb_mem_addr: got %h want 00000020", bus_if.mem_addr); else n_pass++;
        n_total++; if (bus_if.rsp_valid !== 3'b000) $display("FAIL rmb_no_rsp: got %b want 000", bus_if.rsp_valid); else n_pass++;
        clear_inputs();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_illegal();
        test_bus_fault();
        test_timeout();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Three-port memory arbiter and transaction sequencer between the CPU's requesters and the single shared memory port. Port 0 is instruction fetch, port 1 is load/store, port 2 is the external/DMA master. It grants one transaction at a time by round-robin and checks size and alignment before issue. It then drives the memory handshake, enforces a response timeout and returns read data plus a fault code to the owning requester.

## Interface
- TIMEOUT_CYCLES, 255: max cycles in BUSY without `mem_ready` before a timeout fault; legal range 1..65535.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  3  per-port request; held with its fields until acked.
- req_write  in  3  per-port write enable.
- req_size  in  6  2 bits per port: 00 byte, 01 half, 10 word, 11 illegal.
- req_addr  in  96  32 bits per port, port N at [32N+31:32N].
- req_wdata  in  96  32 bits per port.
- req_ack  out  3  one-hot, combinational; request accepted this cycle.
- rsp_valid  out  3  one-hot, registered; one-cycle response pulse to the owner.
- rsp_rdata  out  32  read data, valid with `rsp_valid`; 0 for writes and faults.
- rsp_fault  out  2  00 ok, 01 illegal/misaligned, 10 bus fault, 11 timeout.
- mem_valid  out  1  memory request.
- mem_write, mem_size[1:0], mem_addr[31:0], mem_wdata[31:0]  out  latched transaction fields.
- mem_ready  in  1  memory completion; sampled only while `mem_valid`=1.
- mem_rdata  in  32  read data, valid with `mem_ready`.
- mem_fault  in  1  bus error, valid with `mem_ready`.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE:**
  - If any `req_valid` is set, select the winner by round-robin, searching upward (mod 3) from `rr_ptr`.
  - Assert `req_ack[winner]` combinationally.
  - At the edge: latch the winner's fields and owner index, and set `rr_ptr` = winner+1 mod 3.
  - If size=11, or the address is misaligned (half with addr[0]=1; word with addr[1:0]≠0): set fault=01, rdata=0, go to RESP with no memory access.
  - Otherwise go to BUSY and clear the timeout counter.
- **BUSY:**
  - `mem_valid`=1 and the `mem_*` fields are constant.
  - On an edge with `mem_ready`=1: capture rdata (forced to 0 if write or `mem_fault`), fault = `mem_fault` ? 10 : 00, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 with no ready: fault=11, rdata=0, go to RESP.
  - A `mem_ready` arriving on the same edge as the timeout wins: normal completion.
- **RESP:** `rsp_valid[owner]`=1 for exactly one cycle with `rsp_rdata` and `rsp_fault`; then IDLE. No `req_ack` in BUSY or RESP.
- A request dropped before ack is simply not served. Fields changing before ack are legal; only the values at the ack edge are used.
- `mem_ready` while `mem_valid`=0 is ignored.
- **Reset values:**
  - State IDLE, `rr_ptr`=0, counter 0.
  - Outputs: `mem_valid`=0, `rsp_valid`=000, `rsp_fault`=00, `rsp_rdata`=0, `mem_*` fields 0; `req_ack`=000 during reset.
  - Reset mid-transaction drops `mem_valid` the next cycle and produces no response. The abandoned memory access is the system's responsibility.

## Timing
- **Request side:** ack in cycle N (request visible in IDLE).
- **Memory side:** `mem_valid` rises in N+1.
- **Zero-wait memory (`mem_ready` in N+1):** `rsp_valid` in N+2, next ack earliest N+3. Throughput is 1 transaction per 3 cycles.
- **Memory latency:** a ready after k cycles in BUSY gives `rsp_valid` in N+1+k.
- **Fault responses:**
  - Illegal/misaligned: `rsp_valid` in N+1.
  - Timeout: `rsp_valid` exactly TIMEOUT_CYCLES+1 cycles after ack.
- **Fairness:** each continuously requesting port is acked at least once in any 3 consecutive grants.

## Test plan
- **Single word read:** reset, then port 0 reads addr 0x100 size 10, memory returns `mem_ready` in the first BUSY cycle with rdata 0xDEADBEEF. Required: ack cycle N, `mem_valid` N+1, `rsp_valid`=001 in N+2 with rdata 0xDEADBEEF and fault 00.
- **Round-robin:** all three ports request continuously with zero-wait memory. Required: ack order 0,1,2,0,1,2; `rsp_valid` one-hot matches each owner.
- **Illegal/misaligned:**
  - Port 1 issues a half write at 0x101. Required: `mem_valid` never rises; `rsp_valid`=010 with fault 01 one cycle after ack.
  - Size 11 at 0x0 gives the same result.
- **Bus fault on read:** port 2 word read with `mem_ready`=1 and `mem_fault`=1 after 3 cycles, `mem_rdata`=0x1234. Required: fault 10, rdata 0, `rsp_valid`=100.
- **Timeout (TIMEOUT_CYCLES=4):**
  - `mem_ready` never asserts. Required: `mem_valid` high for exactly 4 cycles, then fault 11; the next request is acked in the following IDLE cycle.
  - Repeat with ready on the 4th BUSY cycle. Required: fault 00.
- **Reset mid-BUSY:** assert reset for one cycle during BUSY. Required: `mem_valid`=0 and `rsp_valid`=000 the next cycle; after release, port 0 wins over a simultaneous port 2 request (`rr_ptr`=0).
